// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 storage with r0 hard-wired to zero,
// same-cycle write-to-read bypass on both read ports and a debug commit counter.
module wb_regfile (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [31:0] ALUOut,
    input  logic [31:0] ReadData,
    input  logic [4:0]  WriteReg,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] WriteData,
    output logic [15:0] WriteCount
);

    logic [31:0] regs_q [32];
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        commit;
    logic [4:0]  rd_idx  [2];
    logic [31:0] rd_data [2];

    assign WriteData = MemtoReg ? ReadData : ALUOut;

    // RST gates the commit so a pending write neither lands nor bypasses while in reset.
    assign commit = RegWrite && (WriteReg != 5'd0) && !RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[WriteReg] <= WriteData;
        end
    end

    always_comb begin
        count_d = count_q;
        if (commit) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign WriteCount = count_q;
    assign rd_idx[0]  = ReadReg1;
    assign rd_idx[1]  = ReadReg2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            always_comb begin
                rd_data[gi] = regs_q[rd_idx[gi]];
                if (rd_idx[gi] == 5'd0) begin
                    rd_data[gi] = '0;
                end else if (commit && (rd_idx[gi] == WriteReg)) begin
                    rd_data[gi] = WriteData;
                end
            end
        end
    endgenerate

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values are queued as stimulus is
// driven and popped against DUT outputs sampled between clock edges.
module tb_wb_regfile;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RegWrite = 1'b0;
    logic        MemtoReg = 1'b0;
    logic [31:0] ALUOut = '0;
    logic [31:0] ReadData = '0;
    logic [4:0]  WriteReg = '0;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData;
    logic [15:0] WriteCount;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_val;

    wb_regfile dut (
        .CLK        (CLK),
        .RST        (RST),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .ALUOut     (ALUOut),
        .ReadData   (ReadData),
        .WriteReg   (WriteReg),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .WriteData  (WriteData),
        .WriteCount (WriteCount)
    );

    always #5 CLK = ~CLK;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, observed);
        end else begin
            expected = exp_q.pop_front();
            assert (observed === expected) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
        end
        $display("vec %0d %s observed=%h", vectors, tag, observed);
    endtask

    initial begin
        // Reset pulsed between edges (edges at 5, 15, ...)
        #1 RST = 1'b1;
        #1 ReadReg1 = 5'd5; ReadReg2 = 5'd31;
        #1;
        push(32'h0); check("rst_rd1", ReadData1);
        push(32'h0); check("rst_rd2", ReadData2);
        push(32'h0); check("rst_cnt", {16'h0, WriteCount});
        #1 RST = 1'b0;

        // Write reg 8 via ALUOut, bypass visible before the edge
        @(negedge CLK);
        RegWrite = 1'b1; MemtoReg = 1'b0; ALUOut = 32'h1234_5678; ReadData = 32'h0BAD_0BAD;
        WriteReg = 5'd8; ReadReg1 = 5'd8;
        #1;
        push(32'h1234_5678); check("wr8_bypass_rd1", ReadData1);
        push(32'h1234_5678); check("wr8_wdata_alu", WriteData);
        @(negedge CLK);
        RegWrite = 1'b0;
        #1;
        push(32'h1234_5678); check("wr8_array_rd1", ReadData1);
        push(32'h1);         check("wr8_cnt", {16'h0, WriteCount});

        // MemtoReg mux and dual-port bypass on reg 9
        @(negedge CLK);
        RegWrite = 1'b1; MemtoReg = 1'b1; ReadData = 32'hDEAD_BEEF; ALUOut = 32'h1111_1111;
        WriteReg = 5'd9; ReadReg1 = 5'd9; ReadReg2 = 5'd9;
        #1;
        push(32'hDEAD_BEEF); check("wr9_bypass_rd1", ReadData1);
        push(32'hDEAD_BEEF); check("wr9_bypass_rd2", ReadData2);
        push(32'hDEAD_BEEF); check("wr9_wdata_mem", WriteData);
        push(32'h1);         check("wr9_cnt_before_edge", {16'h0, WriteCount});
        @(negedge CLK);
        RegWrite = 1'b0; ReadReg1 = 5'd8;
        #1;
        push(32'h1234_5678); check("rd1_reg8", ReadData1);
        push(32'hDEAD_BEEF); check("rd2_reg9", ReadData2);
        push(32'h2);         check("wr9_cnt", {16'h0, WriteCount});

        // Zero register: write discarded, no bypass, count unchanged
        @(negedge CLK);
        RegWrite = 1'b1; MemtoReg = 1'b0; ALUOut = 32'hFFFF_FFFF; WriteReg = 5'd0;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        push(32'h0); check("r0_no_bypass_rd1", ReadData1);
        push(32'hFFFF_FFFF); check("r0_wdata", WriteData);
        @(negedge CLK);
        RegWrite = 1'b0;
        #1;
        push(32'h0); check("r0_rd1", ReadData1);
        push(32'h0); check("r0_rd2", ReadData2);
        push(32'h2); check("r0_cnt", {16'h0, WriteCount});

        // Single-port bypass: port 1 matches, port 2 reads array
        @(negedge CLK);
        RegWrite = 1'b1; ALUOut = 32'hCAFE_0001; WriteReg = 5'd10;
        ReadReg1 = 5'd10; ReadReg2 = 5'd8;
        #1;
        push(32'hCAFE_0001); check("wr10_bypass_rd1", ReadData1);
        push(32'h1234_5678); check("wr10_nobypass_rd2", ReadData2);

        // Back-to-back writes to reg 11
        @(negedge CLK);
        ALUOut = 32'h0000_0001; WriteReg = 5'd11;
        @(negedge CLK);
        ALUOut = 32'h0000_0002;
        @(negedge CLK);
        RegWrite = 1'b0; ReadReg1 = 5'd11; ReadReg2 = 5'd10;
        #1;
        push(32'h0000_0002); check("b2b_reg11", ReadData1);
        push(32'hCAFE_0001); check("rd2_reg10", ReadData2);
        push(32'h5);         check("b2b_cnt", {16'h0, WriteCount});

        // Reset mid-operation with a write to reg 3 pending
        @(negedge CLK);
        RegWrite = 1'b1; ALUOut = 32'hA5A5_A5A5; WriteReg = 5'd3;
        @(negedge CLK);
        RegWrite = 1'b0; ReadReg1 = 5'd3; ReadReg2 = 5'd8;
        #1;
        push(32'hA5A5_A5A5); check("load_reg3", ReadData1);
        push(32'h6);         check("load_reg3_cnt", {16'h0, WriteCount});
        @(negedge CLK);
        RegWrite = 1'b1; ALUOut = 32'h5A5A_5A5A; WriteReg = 5'd3;
        #1 RST = 1'b1;
        #1;
        push(32'h0);         check("rst_async_rd1", ReadData1);
        push(32'h0);         check("rst_async_rd2", ReadData2);
        push(32'h0);         check("rst_async_cnt", {16'h0, WriteCount});
        push(32'h5A5A_5A5A); check("rst_wdata_comb", WriteData);
        @(negedge CLK);
        RST = 1'b0; RegWrite = 1'b0;
        #1;
        push(32'h0); check("post_rst_reg3", ReadData1);
        push(32'h0); check("post_rst_reg8", ReadData2);
        push(32'h0); check("post_rst_cnt", {16'h0, WriteCount});

        // First commit after release
        @(negedge CLK);
        RegWrite = 1'b1; ALUOut = 32'h0000_00C4; WriteReg = 5'd4; ReadReg1 = 5'd4;
        @(negedge CLK);
        RegWrite = 1'b0;
        #1;
        push(32'h0000_00C4); check("first_commit_reg4", ReadData1);
        push(32'h1);         check("first_commit_cnt", {16'h0, WriteCount});

        // Counter wrap: clear, then 65536 commits to reg 1
        @(negedge CLK);
        RST = 1'b1;
        #1 RST = 1'b0;
        last_val = '0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge CLK);
            RegWrite = 1'b1; MemtoReg = 1'b0; WriteReg = 5'd1;
            last_val = 32'h9000_0000 ^ i;
            ALUOut = last_val;
            if (i == 65535) begin
                #1;
                push(32'h0000_FFFF); check("wrap_cnt_ffff", {16'h0, WriteCount});
            end
        end
        @(negedge CLK);
        RegWrite = 1'b0; ReadReg1 = 5'd1;
        #1;
        push(32'h0);     check("wrap_cnt_zero", {16'h0, WriteCount});
        push(last_val);  check("wrap_last_reg1", ReadData1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port RegWrite, input, 1 bit: write-back enable from the MEM/WB register.
REQ-004 The block SHALL have port MemtoReg, input, 1 bit: write-data select; 1 = ReadData, 0 = ALUOut.
REQ-005 The block SHALL have port ALUOut, input, 32 bits: ALU result from the MEM/WB register.
REQ-006 The block SHALL have port ReadData, input, 32 bits: memory load data from the MEM/WB register.
REQ-007 The block SHALL have port WriteReg, input, 5 bits: destination register index.
REQ-008 The block SHALL have port ReadReg1, input, 5 bits: ID-stage source index rs.
REQ-009 The block SHALL have port ReadReg2, input, 5 bits: ID-stage source index rt.
REQ-010 The block SHALL have port ReadData1, output, 32 bits: rs operand value.
REQ-011 The block SHALL have port ReadData2, output, 32 bits: rt operand value.
REQ-012 The block SHALL have port WriteData, output, 32 bits: selected write-back value, exported for forwarding.
REQ-013 The block SHALL have port WriteCount, output, 16 bits: count of committed writes, for debug.

Function
REQ-014 Storage SHALL be 32 registers x 32 bits, indices 0-31.
REQ-015 WriteData SHALL be combinational: MemtoReg ? ReadData : ALUOut.
REQ-016 A write commit SHALL occur at a rising CLK edge when RegWrite=1, WriteReg!=0 and RST=0; reg[WriteReg] <= WriteData.
REQ-017 Writes with WriteReg=0 SHALL be discarded; reg[0] SHALL always read 0.
REQ-018 Reads SHALL be combinational: ReadDataN = reg[ReadRegN] when no bypass applies.
REQ-019 Bypass: when RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg in the same cycle, ReadDataN SHALL equal WriteData (write-before-read within one cycle).
REQ-020 Bypass SHALL apply independently to both ports; both ports SHALL bypass when both match.
REQ-021 ReadRegN=0 SHALL return 0 regardless of RegWrite or WriteReg.
REQ-022 WriteCount SHALL increment by 1 on each commit per REQ-016, SHALL wrap from 0xFFFF to 0x0000, and SHALL not increment on discarded writes.
REQ-023 Back-to-back writes to the same index SHALL leave the value of the later write; no write SHALL be dropped.
REQ-024 Latency: a committed value SHALL be visible via the array on the cycle after the commit edge and via bypass during the commit cycle.

Reset
REQ-025 While RST=1, all 32 registers and WriteCount SHALL be 0, asynchronously, independent of CLK.
REQ-026 RST asserted mid-cycle with a write pending SHALL suppress that write; no register SHALL be nonzero after release.
REQ-027 After RST deasserts, the first commit SHALL occur at the first rising edge with RegWrite=1 and WriteReg!=0.
REQ-028 ReadData1/ReadData2 during reset SHALL reflect the zeroed array; WriteData remains combinational from its inputs.

Verification
REQ-029 Reset: pulse RST between edges, drive ReadReg1=5, ReadReg2=31 -> ReadData1=0, ReadData2=0, WriteCount=0.
REQ-030 Write/read: RegWrite=1, MemtoReg=0, ALUOut=0x12345678, WriteReg=8; edge; RegWrite=0, ReadReg1=8 -> ReadData1=0x12345678, WriteCount=1.
REQ-031 Mux and bypass: RegWrite=1, MemtoReg=1, ReadData=0xDEADBEEF, WriteReg=9, ReadReg1=ReadReg2=9 before the edge -> ReadData1=ReadData2=WriteData=0xDEADBEEF in the same cycle.
REQ-032 Zero register: RegWrite=1, WriteReg=0, ALUOut=0xFFFFFFFF; edge; ReadReg1=0 -> ReadData1=0, WriteCount unchanged.
REQ-033 Reset mid-operation: load reg[3]=0xA5A5A5A5; assert RST with RegWrite=1, WriteReg=3 pending -> after release, reg[3]=0, WriteCount=0.
REQ-034 Counter wrap: 65536 commits to reg 1 -> WriteCount=0x0000; last written value is readable.
